// File: rtl/lc3b_types.sv
// Shared scoreboard types: parameter defaults and the architectural register index type.
package lc3b_types;

    localparam int NUM_REGS_DEF  = 8;
    localparam int NUM_ISSUE_DEF = 1;
    localparam int NUM_WB_DEF    = 2;
    localparam int CNT_W_DEF     = 2;
    localparam int REG_IDX_W     = $clog2(NUM_REGS_DEF);

    typedef logic [REG_IDX_W-1:0] lc3b_reg;

endpackage

// File: rtl/sb_counter.sv
// Per-register pending-writer counter with overflow look-ahead and underflow clamp.
// Optional macro SB_WB_BYPASS_EN: a register being fully released this cycle reads ready at once.
module sb_counter #(
    parameter int CNT_W = 2,
    parameter int EW    = CNT_W + 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic [EW-1:0] req_i,
    input  logic [EW-1:0] inc_i,
    input  logic [EW-1:0] dec_i,
    output logic          ready_o,
    output logic          ovf_o,
    output logic          uflow_o
);

    localparam logic [EW-1:0] CNT_MAX = {2'b00, {CNT_W{1'b1}}};

    logic [CNT_W-1:0] count_d, count_q;
    logic             ready_d, ready_q;
    logic [EW-1:0]    cnt_ext_s;

    assign cnt_ext_s = {2'b00, count_q};

    // Overflow test is rearranged to stay non-negative: count + req > dec + max.
    always_comb begin
        ovf_o = ((cnt_ext_s + req_i) > (dec_i + CNT_MAX));
    end

    // Next count: flush clears, excess releases clamp to zero and flag underflow.
    always_comb begin
        count_d = count_q;
        uflow_o = 1'b0;
        if (flush) begin
            count_d = {CNT_W{1'b0}};
        end else if (dec_i > (cnt_ext_s + inc_i)) begin
            count_d = {CNT_W{1'b0}};
            uflow_o = 1'b1;
        end else begin
            count_d = CNT_W'(cnt_ext_s + inc_i - dec_i);
        end
        ready_d = (count_d == {CNT_W{1'b0}});
    end

    // Count and registered ready flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= {CNT_W{1'b0}};
            ready_q <= 1'b1;
        end else begin
            count_q <= count_d;
            ready_q <= ready_d;
        end
    end

`ifdef SB_WB_BYPASS_EN
    assign ready_o = ready_q | ((dec_i == cnt_ext_s) && (inc_i == {EW{1'b0}}));
`else
    assign ready_o = ready_q;
`endif

endmodule

// File: rtl/reg_scoreboard_mp.sv
// Multi-port register scoreboard: counts pending writers per register across issue/writeback lanes.
// Optional macro SB_WB_BYPASS_EN (see sb_counter) adds a combinational writeback bypass on ready_o.
module reg_scoreboard_mp
    import lc3b_types::*;
#(
    parameter int NUM_REGS  = NUM_REGS_DEF,
    parameter int NUM_ISSUE = NUM_ISSUE_DEF,
    parameter int NUM_WB    = NUM_WB_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_ISSUE-1:0]         iss_valid,
    input  lc3b_reg [NUM_ISSUE-1:0]      iss_idx,
    input  logic                         iss_kill,
    input  logic [NUM_WB-1:0]            wb_valid,
    input  lc3b_reg [NUM_WB-1:0]         wb_idx,
    input  logic                         flush,
    output logic [NUM_REGS-1:0]          ready_o,
    output logic                         iss_stall_o,
    output logic                         err_o
);

    localparam int EW = CNT_W + 2;

    logic [NUM_REGS-1:0][EW-1:0] req_cnt_s, inc_cnt_s, dec_cnt_s;
    logic [NUM_REGS-1:0]         ovf_s, uflow_s;
    logic                        accept_s, stall_s;
    logic                        err_d, err_q;

    // Per-register lane tallies; duplicate lanes to one register each add one.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            req_cnt_s[r] = {EW{1'b0}};
            dec_cnt_s[r] = {EW{1'b0}};
            for (int i = 0; i < NUM_ISSUE; i++) begin
                req_cnt_s[r] = req_cnt_s[r] + EW'(iss_valid[i] && (iss_idx[i] == lc3b_reg'(r)));
            end
            for (int j = 0; j < NUM_WB; j++) begin
                dec_cnt_s[r] = dec_cnt_s[r] + EW'(wb_valid[j] && (wb_idx[j] == lc3b_reg'(r)));
            end
        end
    end

    assign stall_s     = rst_n & (|ovf_s);
    assign accept_s    = ~iss_kill & ~stall_s & ~flush;
    assign iss_stall_o = stall_s;

    // Accepted issues only; a stall or kill rejects every lane together.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            if (accept_s) begin
                inc_cnt_s[r] = req_cnt_s[r];
            end else begin
                inc_cnt_s[r] = {EW{1'b0}};
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_cnt
        sb_counter #(
            .CNT_W (CNT_W),
            .EW    (EW)
        ) u_cnt (
            .clk     (clk),
            .rst_n   (rst_n),
            .flush   (flush),
            .req_i   (req_cnt_s[g]),
            .inc_i   (inc_cnt_s[g]),
            .dec_i   (dec_cnt_s[g]),
            .ready_o (ready_o[g]),
            .ovf_o   (ovf_s[g]),
            .uflow_o (uflow_s[g])
        );
    end

    // Sticky underflow flag; only reset clears it.
    always_comb begin
        err_d = err_q | (|uflow_s);
    end

    // Error flag register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;

endmodule

// File: tb/tb_reg_scoreboard_mp.sv
// Scoreboard bench for reg_scoreboard_mp: stimulus queues expected outputs, a negedge monitor checks them.
module tb_reg_scoreboard_mp;
    import lc3b_types::*;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [0:0]    iss_valid;
    lc3b_reg [0:0] iss_idx;
    logic          iss_kill;
    logic [1:0]    wb_valid;
    lc3b_reg [1:0] wb_idx;
    logic          flush;
    logic [7:0]    ready_o;
    logic          iss_stall_o;
    logic          err_o;

    reg_scoreboard_mp dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .iss_valid   (iss_valid),
        .iss_idx     (iss_idx),
        .iss_kill    (iss_kill),
        .wb_valid    (wb_valid),
        .wb_idx      (wb_idx),
        .flush       (flush),
        .ready_o     (ready_o),
        .iss_stall_o (iss_stall_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

`ifdef SB_WB_BYPASS_EN
    localparam logic [7:0] R3_WB   = 8'hFF;
    localparam logic [7:0] R5_LAST = 8'hFF;
`else
    localparam logic [7:0] R3_WB   = 8'hF7;
    localparam logic [7:0] R5_LAST = 8'hDF;
`endif

    typedef struct {
        string      name;
        int         tag;
        logic [7:0] ready;
        logic       err;
        logic       stall;
    } exp_t;

    exp_t sb_q[$];
    int   neg_cnt = 0;
    int   n_chk   = 0;
    int   n_err   = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    // Monitor: compare every expectation tagged for this sample point.
    always @(negedge clk) begin
        exp_t e;
        while (sb_q.size() > 0 && sb_q[0].tag == neg_cnt) begin
            e = sb_q.pop_front();
            chk({e.name, ".ready"}, ready_o, e.ready);
            chk({e.name, ".err"},   {7'd0, err_o}, {7'd0, e.err});
            chk({e.name, ".stall"}, {7'd0, iss_stall_o}, {7'd0, e.stall});
        end
        neg_cnt = neg_cnt + 1;
    end

    task automatic cyc(input string nm, input logic rn, input logic iv, input int ii, input logic kl,
                       input logic [1:0] wv, input int w0, input int w1, input logic fl,
                       input logic [7:0] er, input logic ee, input logic es);
        exp_t e;
        rst_n        = rn;
        iss_valid[0] = iv;
        iss_idx[0]   = lc3b_reg'(ii);
        iss_kill     = kl;
        wb_valid     = wv;
        wb_idx[0]    = lc3b_reg'(w0);
        wb_idx[1]    = lc3b_reg'(w1);
        flush        = fl;
        e.name  = nm;
        e.tag   = neg_cnt;
        e.ready = er;
        e.err   = ee;
        e.stall = es;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int budget;
        rst_n = 1'b0; iss_valid = 1'b0; iss_idx = '0; iss_kill = 1'b0;
        wb_valid = 2'b00; wb_idx = '0; flush = 1'b0;
        @(posedge clk);
        #1;
        //   name        rn    iv  idx kill  wv    w0 w1 fl    ready   err   stall
        cyc("rst",       1'b0, 1'b0, 0, 1'b0, 2'b00, 0, 0, 1'b0, 8'hFF,  1'b0, 1'b0);
        cyc("idle",      1'b1, 1'b0, 0, 1'b0, 2'b00, 0, 0, 1'b0, 8'hFF,  1'b0, 1'b0);
        cyc("iss_r3",    1'b1, 1'b1, 3, 1'b0, 2'b00, 0, 0, 1'b0, 8'hFF,  1'b0, 1'b0);
        cyc("r3_pend1",  1'b1, 1'b0, 0, 1'b0, 2'b00, 0, 0, 1'b0, 8'hF7,  1'b0, 1'b0);
        cyc("r3_pend2",  1'b1, 1'b0, 0, 1'b0, 2'b00, 0, 0, 1'b0, 8'hF7,  1'b0, 1'b0);
        cyc("wb_r3",     1'b1, 1'b0, 0, 1'b0, 2'b01, 3, 0, 1'b0, R3_WB,  1'b0, 1'b0);
        cyc("r3_free",   1'b1, 1'b0, 0, 1'b0, 2'b00, 0, 0, 1'b0, 8'hFF,  1'b0, 1'b0);
        cyc("iss_r5_a",  1'b1, 1'b1, 5, 1'b0, 2'b00, 0, 0, 1'b0, 8'hFF,  1'b0, 1'b0);
        cyc("iss_r5_b",  1'b1, 1'b1, 5, 1'b0, 2'b00, 0, 0, 1'b0, 8'hDF,  1'b0, 1'b0);
        cyc("iss_r5_c",  1'b1, 1'b1, 5, 1'b0, 2'b00, 0, 0, 1'b0, 8'hDF,  1'b0, 1'b0);
        cyc("r5_ovf",    1'b1, 1'b1, 5, 1'b0, 2'b00, 0, 0, 1'b0, 8'hDF,  1'b0, 1'b1);
        cyc("r5_net",    1'b1, 1'b1, 5, 1'b0, 2'b01, 5, 0, 1'b0, 8'hDF,  1'b0, 1'b0);
        cyc("wb_r5_x2",  1'b1, 1'b0, 0, 1'b0, 2'b11, 5, 5, 1'b0, 8'hDF,  1'b0, 1'b0);
        cyc("wb_r5_x1",  1'b1, 1'b0, 0, 1'b0, 2'b01, 5, 0, 1'b0, R5_LAST,1'b0, 1'b0);
        cyc("r5_free",   1'b1, 1'b0, 0, 1'b0, 2'b00, 0, 0, 1'b0, 8'hFF,  1'b0, 1'b0);
        cyc("kill_r7",   1'b1, 1'b1, 7, 1'b1, 2'b00, 0, 0, 1'b0, 8'hFF,  1'b0, 1'b0);
        cyc("r7_free",   1'b1, 1'b0, 0, 1'b0, 2'b00, 0, 0, 1'b0, 8'hFF,  1'b0, 1'b0);
        cyc("iss_r2",    1'b1, 1'b1, 2, 1'b0, 2'b00, 0, 0, 1'b0, 8'hFF,  1'b0, 1'b0);
        cyc("wb_r2_x2",  1'b1, 1'b0, 0, 1'b0, 2'b11, 2, 2, 1'b0, 8'hFB,  1'b0, 1'b0);
        cyc("uflow",     1'b1, 1'b0, 0, 1'b0, 2'b00, 0, 0, 1'b0, 8'hFF,  1'b1, 1'b0);
        cyc("err_hold",  1'b1, 1'b0, 0, 1'b0, 2'b00, 0, 0, 1'b0, 8'hFF,  1'b1, 1'b0);
        cyc("iss_r1_a",  1'b1, 1'b1, 1, 1'b0, 2'b00, 0, 0, 1'b0, 8'hFF,  1'b1, 1'b0);
        cyc("iss_r1_b",  1'b1, 1'b1, 1, 1'b0, 2'b00, 0, 0, 1'b0, 8'hFD,  1'b1, 1'b0);
        cyc("iss_r6",    1'b1, 1'b1, 6, 1'b0, 2'b00, 0, 0, 1'b0, 8'hFD,  1'b1, 1'b0);
        cyc("flush",     1'b1, 1'b1, 4, 1'b0, 2'b00, 0, 0, 1'b1, 8'hBD,  1'b1, 1'b0);
        cyc("post_flush",1'b1, 1'b0, 0, 1'b0, 2'b00, 0, 0, 1'b0, 8'hFF,  1'b1, 1'b0);
        cyc("iss_r0_a",  1'b1, 1'b1, 0, 1'b0, 2'b00, 0, 0, 1'b0, 8'hFF,  1'b1, 1'b0);
        cyc("iss_r0_b",  1'b1, 1'b1, 0, 1'b0, 2'b00, 0, 0, 1'b0, 8'hFE,  1'b1, 1'b0);
        cyc("iss_r0_c",  1'b1, 1'b1, 0, 1'b0, 2'b00, 0, 0, 1'b0, 8'hFE,  1'b1, 1'b0);
        cyc("rst_stall", 1'b0, 1'b1, 0, 1'b0, 2'b00, 0, 0, 1'b0, 8'hFE,  1'b1, 1'b0);
        cyc("post_rst",  1'b1, 1'b0, 0, 1'b0, 2'b00, 0, 0, 1'b0, 8'hFF,  1'b0, 1'b0);

        budget = 0;
        while (sb_q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        if (sb_q.size() > 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expectations required 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
